// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential convolution cores.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, MAC, NORM, HOLD} state_t;

    // Accumulator wide enough that K*K full-width products never wrap.
    function automatic int acc_w(input int k, input int w);
        return 2 * w + $clog2(k * k + 1) + 1;
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit result.
    function automatic logic signed [127:0] sat_w(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single signed multiply-accumulate with synchronous clear.
module conv_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = 37
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = $signed({{(ACC_W - 2 * DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});

    always_ff @(posedge clk) begin
        if (rst || clear)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/conv_core_kxk_seq.sv
// K x K convolution core with one time-multiplexed MAC and valid/ready on both sides.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
module conv_core_kxk_seq
    import conv_pkg::*;
#(
    parameter int KERNEL     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 Valid_In,
    output logic                                 Ready_In,
    input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Data_In,
    input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Kernel_In,
    input  logic [DATA_WIDTH-1:0]                Bias,
    output logic [DATA_WIDTH-1:0]                Data_Out,
    output logic                                 Valid_Out,
    input  logic                                 Ready_Out
);

    localparam int TAPS  = KERNEL * KERNEL;
    localparam int W     = DATA_WIDTH;
    localparam int ACC_W = acc_w(KERNEL, DATA_WIDTH);
    localparam int NW    = ACC_W + 1;
    localparam int CW    = $clog2(TAPS + 1);
    localparam logic [NW-1:0] RND = NW'((64'd1 << FRAC_BITS) >> 1);

    state_t                  state, state_nx;
    logic [TAPS-1:0][W-1:0]  pix, wgt;
    logic [W-1:0]            bias_q;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    accept;

    logic signed [NW-1:0]    sum, shr;
    logic signed [127:0]     wide;
    logic [W-1:0]            sat_val, norm_val;

    assign Ready_In = (state == IDLE);
    assign accept   = Ready_In && Valid_In;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (Valid_In) state_nx = MAC;
            MAC:  if (cnt == CW'(TAPS - 1)) state_nx = NORM;
            NORM: state_nx = HOLD;
            HOLD: if (Ready_Out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    conv_mac #(.DATA_WIDTH(W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (state == MAC),
        .a     (pix[cnt]),
        .b     (wgt[cnt]),
        .acc   (acc)
    );

    // Bias is aligned to the product's 2*FRAC_BITS scale before rounding back down.
    always_comb begin
        sum      = $signed({acc[ACC_W-1], acc})
                 + $signed({{(NW - W){bias_q[W-1]}}, bias_q} << FRAC_BITS)
                 + $signed(RND);
        shr      = sum >>> FRAC_BITS;
        wide     = $signed({{(128 - NW){shr[NW-1]}}, shr});
        sat_val  = W'(sat_w(wide, W));
        norm_val = sat_val;
`ifdef CONV_RELU_EN
        if (sat_val[W-1])
            norm_val = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix       <= '0;
            wgt       <= '0;
            bias_q    <= '0;
            cnt       <= '0;
            Data_Out  <= '0;
            Valid_Out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    pix    <= Data_In;
                    wgt    <= Kernel_In;
                    bias_q <= Bias;
                    cnt    <= '0;
                end
                MAC:  cnt <= cnt + 1'b1;
                NORM: begin
                    Data_Out  <= norm_val;
                    Valid_Out <= 1'b1;
                end
                HOLD: if (Ready_Out) Valid_Out <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_core_kxk_seq.sv
// Directed vector bench for conv_core_kxk_seq at K=3, W=16, FRAC=8.
module tb_conv_core_kxk_seq;

    localparam int K  = 3;
    localparam int W  = 16;
    localparam int T  = K * K;
    localparam int DW = T * W;
    localparam int NV = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          Valid_In;
    logic          Ready_In;
    logic [DW-1:0] Data_In;
    logic [DW-1:0] Kernel_In;
    logic [W-1:0]  Bias;
    logic [W-1:0]  Data_Out;
    logic          Valid_Out;
    logic          Ready_Out;

    int checks = 0;
    int errors = 0;

    conv_core_kxk_seq #(.KERNEL(K), .DATA_WIDTH(W), .FRAC_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .Valid_In  (Valid_In),
        .Ready_In  (Ready_In),
        .Data_In   (Data_In),
        .Kernel_In (Kernel_In),
        .Bias      (Bias),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out),
        .Ready_Out (Ready_Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] kern;
        logic [W-1:0]  bias;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[NV];

    function automatic logic [DW-1:0] uni(input logic [W-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < T; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] r;
        for (int i = 0; i < T; i++) r[i*W +: W] = W'((i + 1) * 256);
        return r;
    endfunction

    function automatic logic [DW-1:0] onehot(input int idx, input logic [W-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        r[idx*W +: W] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where Valid_Out is first seen.
    task automatic run(input vec_t v, output logic [W-1:0] res, output int lat);
        int guard;
        Data_In   = v.data;
        Kernel_In = v.kern;
        Bias      = v.bias;
        Valid_In  = 1'b1;
        guard = 0;
        while (!Ready_In && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        Valid_In = 1'b0;
        chk("busy_ready_in", {15'd0, Ready_In}, 16'd0);
        lat = 0;
        while (!Valid_Out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = Data_Out;
    endtask

    initial begin
        logic [W-1:0] res;
        int           lat;
        int           seen;
        logic [W-1:0] neg_exp0, neg_exp1, neg_exp2;

`ifdef CONV_RELU_EN
        neg_exp0 = 16'h0000; neg_exp1 = 16'h0000; neg_exp2 = 16'h0000;
`else
        neg_exp0 = 16'hD300; neg_exp1 = 16'h8000; neg_exp2 = 16'hFF80;
`endif
        vecs[0]  = '{uni(16'h0100),   ramp(),              16'h0000, 16'h2D00};
        vecs[1]  = '{uni(16'h0100),   ramp(),              16'h0280, 16'h2F80};
        vecs[2]  = '{onehot(0, 16'h0001), onehot(0, 16'h0080), 16'h0000, 16'h0001};
        vecs[3]  = '{onehot(0, 16'h0001), onehot(0, 16'h007F), 16'h0000, 16'h0000};
        vecs[4]  = '{onehot(0, 16'hFFFF), onehot(0, 16'h0080), 16'h0000, 16'h0000};
        vecs[5]  = '{uni(16'h7FFF),   uni(16'h7FFF),       16'h0000, 16'h7FFF};
        vecs[6]  = '{uni(16'hFF00),   ramp(),              16'h0000, neg_exp0};
        vecs[7]  = '{uni(16'h8000),   uni(16'h7FFF),       16'h0000, neg_exp1};
        vecs[8]  = '{'0,              '0,                  16'hFF80, neg_exp2};
        vecs[9]  = '{ramp(),          onehot(8, 16'h0100), 16'h0000, 16'h0900};
        vecs[10] = '{ramp(),          onehot(0, 16'h0100), 16'h0000, 16'h0100};

        rst = 1'b1; Valid_In = 1'b0; Ready_Out = 1'b1;
        Data_In = '0; Kernel_In = '0; Bias = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid_out", {15'd0, Valid_Out}, 16'd0);
        chk("rst_data_out", Data_Out, 16'h0000);
        chk("rst_ready_in", {15'd0, Ready_In}, 16'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run(vecs[i], res, lat);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 16'(lat), 16'd10);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_drop", i), {15'd0, Valid_Out}, 16'd0);
            chk($sformatf("vec%0d_idle_ready", i), {15'd0, Ready_In}, 16'd1);
        end

        // Back-pressure: result held for 5 cycles, then consumed; next window follows at once.
        Ready_Out = 1'b0;
        run(vecs[0], res, lat);
        chk("bp_data", res, 16'h2D00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data%0d", c), Data_Out, 16'h2D00);
            chk($sformatf("bp_hold_valid%0d", c), {15'd0, Valid_Out}, 16'd1);
            chk($sformatf("bp_hold_ready_in%0d", c), {15'd0, Ready_In}, 16'd0);
        end
        Ready_Out = 1'b1;
        @(negedge clk);
        chk("bp_consumed_valid", {15'd0, Valid_Out}, 16'd0);
        chk("bp_consumed_ready_in", {15'd0, Ready_In}, 16'd1);
        run(vecs[1], res, lat);
        chk("bp_next_data", res, 16'h2F80);
        chk("bp_next_latency", 16'(lat), 16'd10);
        @(negedge clk);

        // Reset in the middle of accumulation aborts the window.
        Data_In = vecs[5].data; Kernel_In = vecs[5].kern; Bias = vecs[5].bias;
        Valid_In = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Valid_In = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready_in", {15'd0, Ready_In}, 16'd1);
        chk("abort_valid_out", {15'd0, Valid_Out}, 16'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (Valid_Out) seen++;
        end
        chk("abort_no_result", 16'(seen), 16'd0);
        run(vecs[0], res, lat);
        chk("abort_next_data", res, 16'h2D00);
        chk("abort_next_latency", 16'(lat), 16'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
